// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Top-level instruction sequencer. It fetches a 16-bit instruction from program
// memory and decodes the opcode in ir[15:12]. For unit opcodes it starts one
// execution FSM (ALU, ALUI, MOV or MOVI) and grants that FSM the shared bus
// until the FSM reports done. It then pulses PC_inc, bumps the retired counter
// and fetches the next instruction. A watchdog traps a memory read or unit
// handshake that never completes. HALT and FAULT are terminal until reset.
//
// Parameters
//   TIMEOUT      cycles allowed in FETCH or WAIT before FAULT (2..255)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   mem_data     instruction word, valid while mem_ready=1
//   mem_ready    memory read complete
//   mem_rd       memory read request (FETCH)
//   PC_inc       one-cycle program counter increment (ADVANCE)
//   ir           latched instruction register
//   unit_start   one-hot start pulse: bit0 ALU, bit1 ALUI, bit2 MOV, bit3 MOVI
//   unit_done    done flags from the execution FSMs, same bit order
//   bus_grant    one-hot bus ownership, same bit order
//   illegal      one-cycle pulse when an undefined opcode is decoded
//   halted       sticky, set by HALT
//   fault        sticky, set by watchdog timeout
//   instr_count  retired-instruction counter, wraps at 16 bits
//
// Every output is Moore: decoded only from the registered state, ir and
// counters, never from an input in the same cycle.
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        PC_inc,
  output logic [15:0] ir,
  output logic [3:0]  unit_start,
  input  logic [3:0]  unit_done,
  output logic [3:0]  bus_grant,
  output logic        illegal,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  // Out-of-range TIMEOUT values would break the 8-bit watchdog compare.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("control_sequencer: TIMEOUT must be in 2..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_DISPATCH,
    ST_WAIT,
    ST_ADVANCE,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALUI = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_MOVI = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  // The watchdog holds the number of cycles already spent in the current
  // FETCH/WAIT visit, so it equals TIMEOUT-1 on the TIMEOUT-th cycle.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  wdog_q, wdog_d;

  logic [3:0]  unit_sel;
  logic        op_nop;
  logic        op_halt;
  logic        op_illegal;
  logic        wdog_expired;
  logic        unit_finished;

  // Opcode decode from the instruction register. unit_sel is the one-hot unit
  // that owns this instruction; it stays zero for NOP, HALT and illegal codes.
  always_comb begin
    unit_sel   = 4'b0000;
    op_nop     = 1'b0;
    op_halt    = 1'b0;
    op_illegal = 1'b0;
    case (ir_q[15:12])
      OP_NOP:  op_nop   = 1'b1;
      OP_ALU:  unit_sel = 4'b0001;
      OP_ALUI: unit_sel = 4'b0010;
      OP_MOV:  unit_sel = 4'b0100;
      OP_MOVI: unit_sel = 4'b1000;
      OP_HALT: op_halt  = 1'b1;
      default: op_illegal = 1'b1;
    endcase
  end

  // Only the done flag of the unit that owns the bus can finish WAIT.
  assign unit_finished = |(unit_done & unit_sel);
  assign wdog_expired  = (wdog_q == WDOG_LAST);

  // State register and datapath flops. Reset wins over every transition, so an
  // instruction in flight is abandoned without retiring.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
      count_q <= 16'h0000;
      wdog_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      count_q <= count_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state logic. The watchdog is cleared on every transition into FETCH
  // or WAIT and counts up while the state is held; completion is checked
  // before expiry so a handshake on the final allowed cycle still succeeds.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    count_d = count_q;
    wdog_d  = wdog_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        wdog_d  = 8'h00;
      end

      ST_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_data;
          state_d = ST_DECODE;
        end else if (wdog_expired) begin
          state_d = ST_FAULT;
        end else begin
          wdog_d = wdog_q + 8'h01;
        end
      end

      ST_DECODE: begin
        if (op_halt) begin
          state_d = ST_HALT;
        end else if (unit_sel != 4'b0000) begin
          state_d = ST_DISPATCH;
        end else begin
          // NOP and illegal opcodes both retire through ADVANCE.
          state_d = ST_ADVANCE;
        end
      end

      ST_DISPATCH: begin
        state_d = ST_WAIT;
        wdog_d  = 8'h00;
      end

      ST_WAIT: begin
        if (unit_finished) begin
          state_d = ST_ADVANCE;
        end else if (wdog_expired) begin
          state_d = ST_FAULT;
        end else begin
          wdog_d = wdog_q + 8'h01;
        end
      end

      ST_ADVANCE: begin
        count_d = count_q + 16'h0001;
        state_d = ST_FETCH;
        wdog_d  = 8'h00;
      end

      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode. The grant is taken from the decoded opcode, which is
  // one-hot by construction, so it can never be multi-hot.
  always_comb begin
    mem_rd     = 1'b0;
    PC_inc     = 1'b0;
    unit_start = 4'b0000;
    bus_grant  = 4'b0000;
    illegal    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    case (state_q)
      ST_FETCH:    mem_rd = 1'b1;
      ST_DECODE:   illegal = op_illegal & ~op_nop;
      ST_DISPATCH: begin
        unit_start = unit_sel;
        bus_grant  = unit_sel;
      end
      ST_WAIT:     bus_grant = unit_sel;
      ST_ADVANCE:  PC_inc = 1'b1;
      ST_HALT:     halted = 1'b1;
      ST_FAULT:    fault = 1'b1;
      default: ;
    endcase
  end

  assign ir          = ir_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Cycle-by-cycle vector bench for control_sequencer with TIMEOUT=4. Each vector
// holds the inputs for one clock cycle plus the outputs expected during it.
// Directed vector tables cover startup, dispatch, wrong-unit done, illegal and
// HALT, and both watchdog paths. Hand-written sequences cover counter wrap and
// reset in the middle of an instruction. A random program is expanded into
// vectors by a timeline model: each instruction costs a known run of FETCH
// cycles, one DECODE, and for unit opcodes one DISPATCH plus d WAIT cycles,
// then one ADVANCE.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        mem_rd;
  logic        PC_inc;
  logic [15:0] ir;
  logic [3:0]  unit_start;
  logic [3:0]  unit_done;
  logic [3:0]  bus_grant;
  logic        illegal;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int checks;
  int failures;

  typedef struct {
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [3:0]  unit_done;
    logic        e_mem_rd;
    logic        e_pc_inc;
    logic        e_illegal;
    logic        e_halted;
    logic        e_fault;
    logic [3:0]  e_start;
    logic [3:0]  e_grant;
    logic [15:0] e_ir;
    logic [15:0] e_count;
  } vec_t;

  vec_t        vq[$];
  vec_t        startup_tbl[11];
  logic [15:0] mdl_ir;
  logic [15:0] mdl_cnt;

  control_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .PC_inc      (PC_inc),
    .ir          (ir),
    .unit_start  (unit_start),
    .unit_done   (unit_done),
    .bus_grant   (bus_grant),
    .illegal     (illegal),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic rdy, input logic [15:0] data,
                               input logic [3:0] done, input logic rd,
                               input logic pc, input logic ill,
                               input logic hlt, input logic flt,
                               input logic [3:0] st, input logic [3:0] gr,
                               input logic [15:0] irv, input logic [15:0] cnt);
    vec_t v;
    v.mem_ready = rdy;
    v.mem_data  = data;
    v.unit_done = done;
    v.e_mem_rd  = rd;
    v.e_pc_inc  = pc;
    v.e_illegal = ill;
    v.e_halted  = hlt;
    v.e_fault   = flt;
    v.e_start   = st;
    v.e_grant   = gr;
    v.e_ir      = irv;
    v.e_count   = cnt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    mem_ready = v.mem_ready;
    mem_data  = v.mem_data;
    unit_done = v.unit_done;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [44:0] act;
    logic [44:0] exp;
    act = {mem_rd, PC_inc, illegal, halted, fault, unit_start, bus_grant,
           ir, instr_count};
    exp = {v.e_mem_rd, v.e_pc_inc, v.e_illegal, v.e_halted, v.e_fault,
           v.e_start, v.e_grant, v.e_ir, v.e_count};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got rd/pc/ill/hlt/flt=%b start=%b grant=%b ir=%h cnt=%h, want rd/pc/ill/hlt/flt=%b start=%b grant=%b ir=%h cnt=%h",
               name, act[44:40], act[39:36], act[35:32], act[31:16], act[15:0],
               exp[44:40], exp[39:36], exp[35:32], exp[31:16], exp[15:0]);
    end
  endtask

  // Holds reset for two rising edges; the next falling edge is in IDLE.
  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    mem_data  = 16'h0000;
    unit_done = 4'b0000;
    repeat (2) @(posedge clk);
  endtask

  // Plays the queued vectors from the IDLE cycle that follows a reset.
  task automatic runVecs(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(vq[i]);
      checkOutput($sformatf("%s[%0d]", name, i), vq[i]);
    end
  endtask

  // Timeline model of one instruction: f stalled FETCH cycles, then DECODE,
  // then for a unit opcode DISPATCH and d WAIT cycles with done on the d-th,
  // then ADVANCE. Inputs the design must ignore are randomised.
  task automatic genInstr(input logic [15:0] instr, input int f, input int d);
    logic [3:0] oh;
    logic       ill;
    for (int j = 0; j <= f; j++) begin
      vq.push_back(mkv(j == f, (j == f) ? instr : 16'($urandom), 4'($urandom),
                       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000,
                       mdl_ir, mdl_cnt));
    end
    mdl_ir = instr;
    case (instr[15:12])
      4'h1:    oh = 4'b0010;
      4'h2:    oh = 4'b0001;
      4'h3:    oh = 4'b0100;
      4'h4:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    ill = (instr[15:12] != 4'h0) && (oh == 4'b0000);
    vq.push_back(mkv(1'($urandom_range(1)), 16'($urandom), 4'($urandom),
                     1'b0, 1'b0, ill, 1'b0, 1'b0, 4'b0000, 4'b0000,
                     mdl_ir, mdl_cnt));
    if (oh != 4'b0000) begin
      vq.push_back(mkv(1'($urandom_range(1)), 16'($urandom), 4'($urandom),
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, oh, oh, mdl_ir, mdl_cnt));
      for (int w = 1; w <= d; w++) begin
        vq.push_back(mkv(1'($urandom_range(1)), 16'($urandom),
                         (4'($urandom) & ~oh) | ((w == d) ? oh : 4'b0000),
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, oh,
                         mdl_ir, mdl_cnt));
      end
    end
    vq.push_back(mkv(1'($urandom_range(1)), 16'($urandom), 4'($urandom),
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000,
                     mdl_ir, mdl_cnt));
    mdl_cnt = mdl_cnt + 16'h0001;
  endtask

  function automatic vec_t idleVec(input logic rdy, input logic [15:0] data);
    return mkv(rdy, data, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               4'b0000, 4'b0000, 16'h0000, 16'h0000);
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    mem_ready = 1'b0;
    mem_data  = 16'h0000;
    unit_done = 4'b0000;

    // Startup table: NOPs with mem_ready high retire every 3 cycles.
    startup_tbl[0] = idleVec(1'b1, 16'h0000);
    for (int n = 0; n < 3; n++) begin
      startup_tbl[1 + 3*n] = mkv(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'(n));
      startup_tbl[2 + 3*n] = mkv(1'b1, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'(n));
      startup_tbl[3 + 3*n] = mkv(1'b1, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'(n));
    end
    startup_tbl[10] = mkv(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                          4'b0000, 4'b0000, 16'h0000, 16'h0003);

    resetDut();
    vq.delete();
    foreach (startup_tbl[i]) vq.push_back(startup_tbl[i]);
    runVecs("startup");

    // ALUI, done raised 3 cycles after the start pulse.
    resetDut();
    vq.delete();
    vq.push_back(idleVec(1'b1, 16'h1002));
    vq.push_back(mkv(1'b1, 16'h1002, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h1002, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 16'h1002, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 16'h1002, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 16'h1002, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 16'h1002, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h1002, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h1002, 16'h0001));
    runVecs("alui");

    // ALU with a stray MOV done first; only bit0 may finish WAIT.
    resetDut();
    vq.delete();
    vq.push_back(idleVec(1'b1, 16'h2000));
    vq.push_back(mkv(1'b1, 16'h2000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h2000, 16'h0001));
    runVecs("wrong_done");

    // Illegal opcode, then HALT; HALT holds for 20 cycles with memory ready.
    resetDut();
    vq.delete();
    vq.push_back(idleVec(1'b1, 16'h7000));
    vq.push_back(mkv(1'b1, 16'h7000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    vq.push_back(mkv(1'b1, 16'hF000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h7000, 16'h0000));
    vq.push_back(mkv(1'b1, 16'hF000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h7000, 16'h0000));
    vq.push_back(mkv(1'b1, 16'hF000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h7000, 16'h0001));
    vq.push_back(mkv(1'b1, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'hF000, 16'h0001));
    for (int i = 0; i < 20; i++)
      vq.push_back(mkv(1'b1, 16'h2000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 16'hF000, 16'h0001));
    runVecs("halt");

    // MOV whose done never comes: FAULT after the 4th WAIT cycle.
    resetDut();
    vq.delete();
    vq.push_back(idleVec(1'b1, 16'h3000));
    vq.push_back(mkv(1'b1, 16'h3000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h3000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 16'h3000, 16'h0000));
    for (int w = 0; w < 4; w++)
      vq.push_back(mkv(1'b0, 16'h0000, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 16'h3000, 16'h0000));
    for (int i = 0; i < 4; i++)
      vq.push_back(mkv(1'b1, 16'h0000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 16'h3000, 16'h0000));
    runVecs("wait_timeout");

    // Reset clears fault; MOV done on exactly the 4th WAIT cycle succeeds.
    resetDut();
    vq.delete();
    vq.push_back(idleVec(1'b1, 16'h3000));
    vq.push_back(mkv(1'b1, 16'h3000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h3000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 16'h3000, 16'h0000));
    for (int w = 1; w <= 4; w++)
      vq.push_back(mkv(1'b0, 16'h0000, (w == 4) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       4'b0000, 4'b0100, 16'h3000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h3000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h3000, 16'h0001));
    runVecs("wait_edge");

    // FETCH with memory never ready: FAULT after the 4th FETCH cycle.
    resetDut();
    vq.delete();
    vq.push_back(idleVec(1'b0, 16'h0000));
    for (int j = 0; j < 4; j++)
      vq.push_back(mkv(1'b0, 16'h1234, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    for (int i = 0; i < 3; i++)
      vq.push_back(mkv(1'b1, 16'h1234, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    runVecs("fetch_timeout");

    // Counter wrap: preload FFFF in the IDLE cycle, then retire one NOP.
    resetDut();
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_data  = 16'h0000;
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_advance", mkv(1'b1, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                    4'b0000, 4'b0000, 16'h0000, 16'hFFFF));
    @(negedge clk);
    checkOutput("wrap_after", mkv(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  4'b0000, 4'b0000, 16'h0000, 16'h0000));

    // Reset during WAIT of an ALU instruction aborts it without retiring.
    resetDut();
    vq.delete();
    vq.push_back(idleVec(1'b1, 16'h2000));
    vq.push_back(mkv(1'b1, 16'h2000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 16'h2000, 16'h0000));
    vq.push_back(mkv(1'b0, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 16'h2000, 16'h0000));
    runVecs("midop_pre");
    rst = 1'b1;
    vq.delete();
    vq.push_back(idleVec(1'b0, 16'h0000));
    for (int j = 0; j < 3; j++)
      vq.push_back(mkv(1'b0, 16'h0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    runVecs("midop_post");

    // Random program against the timeline model.
    resetDut();
    vq.delete();
    mdl_ir  = 16'h0000;
    mdl_cnt = 16'h0000;
    vq.push_back(mkv(1'($urandom_range(1)), 16'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 16'h0000));
    for (int n = 0; n < 40; n++) begin
      genInstr({4'($urandom_range(14)), 12'($urandom)},
               int'($urandom_range(TIMEOUT - 1)), int'($urandom_range(TIMEOUT, 1)));
    end
    runVecs("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
